// File: rtl/pacman_snd_pkg.sv
// Shared widths, end-of-sound marker and sequencer state encoding for the
// Pac-Man sound sequencer.
package pacman_snd_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 9;

    localparam logic [DATA_W-1:0] END_CODE = 9'd511;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        FINISH
    } state_t;

endpackage

// File: rtl/pacman_tone_gen.sv
// Square-wave tone generator: a CLK_DIV prescaler feeds a half-period counter,
// and the speaker level toggles every `period` unit ticks.
module pacman_tone_gen
    import pacman_snd_pkg::*;
#(
    parameter int CLK_DIV = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] period,
    input  logic              mute,
    output logic              spk
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]     pre;
    logic [DATA_W-1:0] half;
    logic              lvl;
    logic              tick;
    logic              flip;
    logic              audible;

    assign tick    = (pre == PRE_LAST);
    assign audible = (period != '0);
    assign flip    = tick && audible && (half == period - DATA_W'(1));

    // spk is registered alongside the toggle so its edges line up with lvl;
    // mute only gates the pin, the counters keep running underneath.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            pre  <= '0;
            half <= '0;
            lvl  <= 1'b0;
            spk  <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
            if (tick)
                half <= (flip || !audible) ? '0 : half + DATA_W'(1);
            lvl <= lvl ^ flip;
            spk <= (lvl ^ flip) && !mute && audible;
        end
    end

endmodule

// File: rtl/pacman_sound_seq.sv
// Sound sequencer: walks an external registered ROM, playing each sample as a
// tone for STEP_CYCLES cycles until the end code or LAST_ADDR is reached.
module pacman_sound_seq
    import pacman_snd_pkg::*;
#(
    parameter int CLK_DIV     = 64,
    parameter int STEP_CYCLES = 100000,
    parameter int LAST_ADDR   = 120
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mute,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              spk,
    output logic              busy,
    output logic              done
);

    localparam int SW = $clog2(STEP_CYCLES);
    localparam logic [SW-1:0]     STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LAST_ADDR);

    state_t            state;
    logic [DATA_W-1:0] period;
    logic [SW-1:0]     step;
    logic              step_last;
    logic              tone_clear;

    assign step_last = (step == STEP_LAST);

    // Hold the tone generator cleared whenever the next cycle is not PLAY, so
    // spk is already low in the first FETCH/FINISH cycle after a sample.
    assign tone_clear = (state != PLAY) || step_last || start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            period   <= '0;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (start)
                        rom_addr <= '0;
                    else
                        state <= LOAD;
                end
                LOAD: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                    end else begin
                        period <= rom_data;
                        step   <= '0;
                        if (rom_data == END_CODE) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                        end else begin
                            state <= PLAY;
                        end
                    end
                end
                PLAY: begin
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                    end else if (step_last) begin
                        if (rom_addr == ADDR_LAST) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                        end else begin
                            state    <= FETCH;
                            rom_addr <= rom_addr + ADDR_W'(1);
                        end
                    end else begin
                        step <= step + SW'(1);
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (start) begin
                        state    <= FETCH;
                        rom_addr <= '0;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    pacman_tone_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tone (
        .clk    (clk),
        .rst    (rst),
        .clear  (tone_clear),
        .period (period),
        .mute   (mute),
        .spk    (spk)
    );

endmodule

// File: tb/tb_pacman_sound_seq.sv
// Directed bench for pacman_sound_seq with a behavioural 1-cycle ROM,
// CLK_DIV=2 and STEP_CYCLES=20 so each sample costs 22 cycles.
module tb_pacman_sound_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       mute;
    logic [6:0] rom_addr;
    logic [8:0] rom_data;
    logic       spk;
    logic       busy;
    logic       done;

    logic [8:0] rom [0:127];

    int n_chk  = 0;
    int n_pass = 0;

    int d_h [0:63];
    int b_h [0:63];
    int s_h [0:63];
    int a_h [0:63];

    pacman_sound_seq #(
        .CLK_DIV     (2),
        .STEP_CYCLES (20),
        .LAST_ADDR   (120)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mute     (mute),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .spk      (spk),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < 128; i++)
            rom[i] = (i <= 120) ? 9'((base == 0) ? (i % 7) + 1 : base) : 9'd511;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int dcnt, bcnt, maxa, adone, guard, blo, hi;
        clk   = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        mute  = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 9'd511;

        // reset state, with start held to show reset wins
        start = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spk",  spk,  0);
        chk("rst_addr", rom_addr, 0);
        start = 1'b0;
        rst   = 1'b0;
        tick();

        // single period-3 sample, then end code
        rom[0] = 9'd3;
        rom[1] = 9'd511;
        pulse_start();
        chk("t1_busy_rise", busy, 1);
        chk("t1_addr0", rom_addr, 0);
        tick();
        tick();
        for (int k = 0; k <= 20; k++) begin
            s_h[k] = spk;
            a_h[k] = rom_addr;
            tick();
        end
        chk("t1_spk_k5",  s_h[5],  0);
        chk("t1_spk_k6",  s_h[6],  1);
        chk("t1_spk_k11", s_h[11], 1);
        chk("t1_spk_k12", s_h[12], 0);
        chk("t1_spk_k17", s_h[17], 0);
        chk("t1_spk_k18", s_h[18], 1);
        chk("t1_addr_k19", a_h[19], 0);
        chk("t1_addr_k20", a_h[20], 1);
        repeat (4) tick();

        // two period-5 samples then end code: done timing
        rom[0] = 9'd5;
        rom[1] = 9'd5;
        rom[2] = 9'd511;
        pulse_start();
        dcnt = 0;
        for (int c = 1; c <= 55; c++) begin
            d_h[c] = done;
            b_h[c] = busy;
            s_h[c] = spk;
            dcnt += int'(done);
            tick();
        end
        chk("t2_done_count", dcnt, 1);
        chk("t2_done_at48", d_h[48], 1);
        chk("t2_busy_load", b_h[46], 1);
        chk("t2_busy_after", b_h[49], 0);
        chk("t2_spk_finish", s_h[47], 0);
        chk("t2_spk_c12", s_h[12], 0);
        chk("t2_spk_c13", s_h[13], 1);

        // full table, no end code before LAST_ADDR
        fill(0);
        pulse_start();
        dcnt = 0; bcnt = 0; maxa = 0; adone = -1; guard = 0;
        while (dcnt == 0 && guard < 3000) begin
            bcnt += int'(busy);
            if (int'(rom_addr) > maxa) maxa = int'(rom_addr);
            if (done) begin
                dcnt++;
                adone = int'(rom_addr);
            end
            guard++;
            if (dcnt == 0) tick();
        end
        chk("t3_done_count", dcnt, 1);
        chk("t3_busy_cycles", bcnt, 121 * 22);
        chk("t3_max_addr", maxa, 120);
        chk("t3_addr_at_done", adone, 120);
        tick();

        // retrigger in PLAY at address 37, then start during FINISH
        pulse_start();
        guard = 0;
        while (rom_addr != 7'd37 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("t4_reach37", rom_addr, 37);
        repeat (5) tick();
        chk("t4_busy_play", busy, 1);
        rom[0] = 9'd4;
        rom[1] = 9'd511;
        pulse_start();
        chk("t4_retrig_addr", rom_addr, 0);
        chk("t4_retrig_busy", busy, 1);
        dcnt = 0; blo = 0;
        for (int r = 0; r <= 23; r++) begin
            dcnt += int'(done);
            blo  += int'(!busy);
            tick();
        end
        chk("t4_no_done", dcnt, 0);
        chk("t4_busy_held", blo, 0);
        chk("t4_spk_finish", spk, 0);
        pulse_start();
        chk("t4_fin_done", done, 1);
        chk("t4_fin_busy", busy, 1);
        chk("t4_fin_addr", rom_addr, 0);
        repeat (30) tick();
        chk("t4_idle", busy, 0);

        // reset mid-sound at address 10 with spk high
        fill(1);
        pulse_start();
        repeat (224) tick();
        chk("t5_pre_addr", rom_addr, 10);
        chk("t5_pre_spk", spk, 1);
        rst = 1'b1;
        tick();
        chk("t5_spk", spk, 0);
        chk("t5_busy", busy, 0);
        chk("t5_addr", rom_addr, 0);
        chk("t5_done", done, 0);
        rom[0] = 9'd3;
        start  = 1'b1;
        tick();
        chk("t5_rst_prio", busy, 0);
        rst = 1'b0;
        tick();
        start = 1'b0;
        chk("t5_restart_busy", busy, 1);
        tick();
        tick();
        repeat (6) tick();
        chk("t5_restart_spk", spk, 1);
        chk("t5_restart_addr", rom_addr, 0);
        do_reset();
        tick();

        // silent sample, then a muted period-4 sample
        rom[0] = 9'd0;
        rom[1] = 9'd4;
        rom[2] = 9'd511;
        pulse_start();
        hi = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c == 23) mute = 1'b1;
            hi += int'(spk);
            a_h[c] = rom_addr;
            d_h[c] = done;
            tick();
        end
        mute = 1'b0;
        chk("t6_spk_low", hi, 0);
        chk("t6_addr_c22", a_h[22], 0);
        chk("t6_addr_c23", a_h[23], 1);
        chk("t6_addr_c44", a_h[44], 1);
        chk("t6_addr_c45", a_h[45], 2);
        chk("t6_done_c48", d_h[48], 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
